// File: rtl/nios_dpram_pkg.sv
// rtl/nios_dpram_pkg.sv - shared types, latency limits and byte-merge helper for the dual-port RAM
// Contents:
//   state_t     : RESET / CLEAR / RUN states of the zero-fill sequencer
//   RD_LAT_MIN/MAX : legal read-latency range
//   byte_merge  : per-lane merge (old word, new word, byteenable -> merged word)
package nios_dpram_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int MERGE_W = 256;
    localparam int MERGE_B = MERGE_W / 8;

    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0] old_word,
        input logic [MERGE_W-1:0] new_word,
        input logic [MERGE_B-1:0] byteenable
    );
        logic [MERGE_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MERGE_B; i++) begin
            if (byteenable[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/nios_dpram_rd_pipe.sv
// rtl/nios_dpram_rd_pipe.sv - LATENCY-deep read valid/data pipeline with asynchronous clear
// Ports:
//   clk, reset       : clock, asynchronous active-high clear of all stages
//   req, req_data    : read accepted this cycle and its (already forwarded) word
//   valid, data      : pipeline output; data holds its last value while valid is low
module nios_dpram_rd_pipe #(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [DATA_W-1:0] req_data,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    logic              vld [LATENCY];
    logic [DATA_W-1:0] dat [LATENCY];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld[i] <= 1'b0;
                dat[i] <= '0;
            end
        end else begin
            vld[0] <= req;
            if (req) begin
                dat[0] <= req_data;
            end
            // Data registers only load behind a valid so the output holds between reads.
            for (int i = 1; i < LATENCY; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    dat[i] <= dat[i-1];
                end
            end
        end
    end

    assign valid = vld[LATENCY-1];
    assign data  = dat[LATENCY-1];

endmodule

// File: rtl/nios_dpram_pipelined.sv
// rtl/nios_dpram_pipelined.sv - dual-port Avalon-MM on-chip RAM with read latency, zero-fill and write-first forwarding
// Ports (per port X in {a, b}):
//   x_chipselect, x_read, x_write, x_address, x_byteenable, x_writedata : command
//   x_readdata, x_readdatavalid : registered read response, READ_LATENCY after acceptance
//   x_waitrequest               : high until the post-reset fill has finished
// clk is shared by both ports; reset is asynchronous active-high.
module nios_dpram_pipelined
    import nios_dpram_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 50000,
    parameter int ADDR_W         = 16,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                a_chipselect,
    input  logic                a_read,
    input  logic                a_write,
    input  logic [ADDR_W-1:0]   a_address,
    input  logic [DATA_W/8-1:0] a_byteenable,
    input  logic [DATA_W-1:0]   a_writedata,
    output logic [DATA_W-1:0]   a_readdata,
    output logic                a_readdatavalid,
    output logic                a_waitrequest,
    input  logic                b_chipselect,
    input  logic                b_read,
    input  logic                b_write,
    input  logic [ADDR_W-1:0]   b_address,
    input  logic [DATA_W/8-1:0] b_byteenable,
    input  logic [DATA_W-1:0]   b_writedata,
    output logic [DATA_W-1:0]   b_readdata,
    output logic                b_readdatavalid,
    output logic                b_waitrequest
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LAT   = (READ_LATENCY < RD_LAT_MIN) ? RD_LAT_MIN :
                           (READ_LATENCY > RD_LAT_MAX) ? RD_LAT_MAX : READ_LATENCY;
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    logic [ADDR_W-1:0] fill_cnt;
    logic              busy;
    logic              fill_we;

    assign busy          = (state != ST_RUN);
    assign a_waitrequest = busy;
    assign b_waitrequest = busy;

    // The edge that leaves RESET already clears word 0, so the fill occupies
    // exactly DEPTH cycles of waitrequest after release.
    assign fill_we = (CLEAR_ON_RESET != 0) && (state == ST_RESET || state == ST_CLEAR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_RESET;
            fill_cnt <= '0;
        end else begin
            case (state)
                ST_RESET: begin
                    if (CLEAR_ON_RESET == 0 || fill_cnt == LAST_WORD) begin
                        state <= ST_RUN;
                    end else begin
                        state    <= ST_CLEAR;
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (fill_cnt == LAST_WORD) begin
                        state <= ST_RUN;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Command decode; a read issued together with a write on the same port is dropped.
    logic              a_wr, a_rd, a_in, a_we;
    logic              b_wr, b_rd, b_in, b_we;
    logic [IDX_W-1:0]  a_idx, b_idx;

    assign a_wr  = a_chipselect & a_write & ~busy;
    assign a_rd  = a_chipselect & a_read & ~a_write & ~busy;
    assign a_in  = ({1'b0, a_address} < DEPTH_X);
    assign a_we  = a_wr & a_in;
    assign a_idx = a_address[IDX_W-1:0];

    assign b_wr  = b_chipselect & b_write & ~busy;
    assign b_rd  = b_chipselect & b_read & ~b_write & ~busy;
    assign b_in  = ({1'b0, b_address} < DEPTH_X);
    assign b_we  = b_wr & b_in;
    assign b_idx = b_address[IDX_W-1:0];

    // B's lanes are written before A's so that on a same-address collision
    // A's enabled bytes win and B fills the remaining enabled lanes.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            mem[fill_cnt[IDX_W-1:0]] <= '0;
        end
        for (int i = 0; i < BE_W; i++) begin
            if (b_we && b_byteenable[i]) begin
                mem[b_idx][i*8 +: 8] <= b_writedata[i*8 +: 8];
            end
            if (a_we && a_byteenable[i]) begin
                mem[a_idx][i*8 +: 8] <= a_writedata[i*8 +: 8];
            end
        end
    end

    function automatic logic [DATA_W-1:0] merge_w(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        return DATA_W'(byte_merge(MERGE_W'(old_word), MERGE_W'(new_word), MERGE_B'(be)));
    endfunction

    // Write-first: the read sees the word as it will be after this edge's
    // writes, applied in the same B-then-A order as the array update.
    logic [DATA_W-1:0] a_rword, b_rword;

    always_comb begin
        a_rword = '0;
        if (a_in) begin
            a_rword = mem[a_idx];
            if (b_we && b_idx == a_idx) a_rword = merge_w(a_rword, b_writedata, b_byteenable);
            if (a_we) a_rword = merge_w(a_rword, a_writedata, a_byteenable);
        end
    end

    always_comb begin
        b_rword = '0;
        if (b_in) begin
            b_rword = mem[b_idx];
            if (b_we) b_rword = merge_w(b_rword, b_writedata, b_byteenable);
            if (a_we && a_idx == b_idx) b_rword = merge_w(b_rword, a_writedata, a_byteenable);
        end
    end

    nios_dpram_rd_pipe #(.DATA_W(DATA_W), .LATENCY(LAT)) u_a_pipe (
        .clk      (clk),
        .reset    (reset),
        .req      (a_rd),
        .req_data (a_rword),
        .valid    (a_readdatavalid),
        .data     (a_readdata)
    );

    nios_dpram_rd_pipe #(.DATA_W(DATA_W), .LATENCY(LAT)) u_b_pipe (
        .clk      (clk),
        .reset    (reset),
        .req      (b_rd),
        .req_data (b_rword),
        .valid    (b_readdatavalid),
        .data     (b_readdata)
    );

endmodule

// File: tb/tb_nios_dpram_pipelined.sv
// tb/tb_nios_dpram_pipelined.sv - table-driven bench for nios_dpram_pipelined (latency 1 and 2, with and without fill)
module tb_nios_dpram_pipelined;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        a_cs, a_rd, a_wr, b_cs, b_rd, b_wr;
    logic [3:0]  a_addr, a_be, b_addr, b_be;
    logic [31:0] a_wd, b_wd;

    logic [31:0] r1_a_d, r1_b_d, r2_a_d, r2_b_d, r0_a_d, r0_b_d;
    logic        r1_a_v, r1_b_v, r2_a_v, r2_b_v, r0_a_v, r0_b_v;
    logic        r1_a_w, r1_b_w, r2_a_w, r2_b_w, r0_a_w, r0_b_w;

    nios_dpram_pipelined #(.DATA_W(32), .DEPTH(8), .ADDR_W(4), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut1 (
        .clk(clk), .reset(reset),
        .a_chipselect(a_cs), .a_read(a_rd), .a_write(a_wr), .a_address(a_addr),
        .a_byteenable(a_be), .a_writedata(a_wd), .a_readdata(r1_a_d),
        .a_readdatavalid(r1_a_v), .a_waitrequest(r1_a_w),
        .b_chipselect(b_cs), .b_read(b_rd), .b_write(b_wr), .b_address(b_addr),
        .b_byteenable(b_be), .b_writedata(b_wd), .b_readdata(r1_b_d),
        .b_readdatavalid(r1_b_v), .b_waitrequest(r1_b_w)
    );

    nios_dpram_pipelined #(.DATA_W(32), .DEPTH(8), .ADDR_W(4), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut2 (
        .clk(clk), .reset(reset),
        .a_chipselect(a_cs), .a_read(a_rd), .a_write(a_wr), .a_address(a_addr),
        .a_byteenable(a_be), .a_writedata(a_wd), .a_readdata(r2_a_d),
        .a_readdatavalid(r2_a_v), .a_waitrequest(r2_a_w),
        .b_chipselect(b_cs), .b_read(b_rd), .b_write(b_wr), .b_address(b_addr),
        .b_byteenable(b_be), .b_writedata(b_wd), .b_readdata(r2_b_d),
        .b_readdatavalid(r2_b_v), .b_waitrequest(r2_b_w)
    );

    nios_dpram_pipelined #(.DATA_W(32), .DEPTH(8), .ADDR_W(4), .READ_LATENCY(1), .CLEAR_ON_RESET(0)) dut0 (
        .clk(clk), .reset(reset),
        .a_chipselect(a_cs), .a_read(a_rd), .a_write(a_wr), .a_address(a_addr),
        .a_byteenable(a_be), .a_writedata(a_wd), .a_readdata(r0_a_d),
        .a_readdatavalid(r0_a_v), .a_waitrequest(r0_a_w),
        .b_chipselect(b_cs), .b_read(b_rd), .b_write(b_wr), .b_address(b_addr),
        .b_byteenable(b_be), .b_writedata(b_wd), .b_readdata(r0_b_d),
        .b_readdatavalid(r0_b_v), .b_waitrequest(r0_b_w)
    );

    typedef struct packed {
        logic        cs;
        logic        rd;
        logic        wr;
        logic [3:0]  addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } cmd_t;

    typedef struct {
        cmd_t        a;
        cmd_t        b;
        logic        ea_v;
        logic [31:0] ea_d;
        logic        eb_v;
        logic [31:0] eb_d;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Latency-2 expectation: the latency-1 expectation of the previous vector.
    logic        p_av, p_bv;
    logic [31:0] p_ad, p_bd;

    vec_t tbl[$];

    function automatic cmd_t mk_cmd(input logic cs, input logic rd, input logic wr,
                                    input logic [3:0] ad, input logic [3:0] be, input logic [31:0] wd);
        cmd_t c;
        c.cs = cs; c.rd = rd; c.wr = wr; c.addr = ad; c.be = be; c.wd = wd;
        return c;
    endfunction

    function automatic cmd_t c_idle();
        return mk_cmd(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    endfunction

    function automatic cmd_t c_rd(input logic [3:0] ad);
        return mk_cmd(1'b1, 1'b1, 1'b0, ad, 4'h0, 32'h0);
    endfunction

    function automatic cmd_t c_wr(input logic [3:0] ad, input logic [3:0] be, input logic [31:0] wd);
        return mk_cmd(1'b1, 1'b0, 1'b1, ad, be, wd);
    endfunction

    function automatic vec_t mkv(input cmd_t a, input cmd_t b, input logic eav, input logic [31:0] ead,
                                 input logic ebv, input logic [31:0] ebd);
        vec_t v;
        v.a = a; v.b = b; v.ea_v = eav; v.ea_d = ead; v.eb_v = ebv; v.eb_d = ebd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input cmd_t a, input cmd_t b);
        a_cs = a.cs; a_rd = a.rd; a_wr = a.wr; a_addr = a.addr; a_be = a.be; a_wd = a.wd;
        b_cs = b.cs; b_rd = b.rd; b_wr = b.wr; b_addr = b.addr; b_be = b.be; b_wd = b.wd;
    endtask

    task automatic apply(input vec_t v, input string tag);
        drive(v.a, v.b);
        @(posedge clk);
        @(negedge clk);
        chk({tag, " a_valid L1"}, 32'(r1_a_v), 32'(v.ea_v));
        if (v.ea_v) chk({tag, " a_data L1"}, r1_a_d, v.ea_d);
        chk({tag, " b_valid L1"}, 32'(r1_b_v), 32'(v.eb_v));
        if (v.eb_v) chk({tag, " b_data L1"}, r1_b_d, v.eb_d);
        chk({tag, " a_valid L2"}, 32'(r2_a_v), 32'(p_av));
        if (p_av) chk({tag, " a_data L2"}, r2_a_d, p_ad);
        chk({tag, " b_valid L2"}, 32'(r2_b_v), 32'(p_bv));
        if (p_bv) chk({tag, " b_data L2"}, r2_b_d, p_bd);
        p_av = v.ea_v; p_ad = v.ea_d; p_bv = v.eb_v; p_bd = v.eb_d;
    endtask

    // Called at the negedge where reset has just been released.
    task automatic measure_fill(input string tag);
        int ha, hb, h2, h0, sv;
        ha = int'(r1_a_w); hb = int'(r1_b_w); h2 = int'(r2_a_w); h0 = int'(r0_a_w); sv = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            ha += int'(r1_a_w);
            hb += int'(r1_b_w);
            h2 += int'(r2_a_w);
            h0 += int'(r0_a_w);
            sv += int'(r1_a_v) + int'(r1_b_v) + int'(r2_a_v) + int'(r2_b_v);
        end
        chk({tag, " a_wait cycles"}, 32'(ha), 32'd8);
        chk({tag, " b_wait cycles"}, 32'(hb), 32'd8);
        chk({tag, " L2 wait cycles"}, 32'(h2), 32'd8);
        chk({tag, " noclear wait cycles"}, 32'(h0), 32'd1);
        chk({tag, " stray valids"}, 32'(sv), 32'd0);
        chk({tag, " wait low after"}, 32'(r1_a_w), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        drive(c_idle(), c_idle());
        p_av = 1'b0; p_ad = '0; p_bv = 1'b0; p_bd = '0;
        repeat (3) @(negedge clk);

        chk("rst a_data", r1_a_d, 32'h0);
        chk("rst b_data", r1_b_d, 32'h0);
        chk("rst a_valid", 32'(r1_a_v), 32'd0);
        chk("rst b_valid", 32'(r1_b_v), 32'd0);
        chk("rst a_wait", 32'(r1_a_w), 32'd1);
        chk("rst b_wait", 32'(r1_b_w), 32'd1);
        chk("rst L2 b_data", r2_b_d, 32'h0);
        chk("rst noclear wait", 32'(r0_a_w), 32'd1);

        reset = 1'b0;
        measure_fill("fill1");

        for (int i = 0; i < 8; i++) begin
            tbl.push_back(mkv(c_rd(4'(i)), c_rd(4'(7 - i)), 1'b1, 32'h0, 1'b1, 32'h0));
        end
        tbl.push_back(mkv(c_wr(4'd3, 4'hF, 32'h11223344), c_idle(), 1'b0, 32'h0, 1'b0, 32'h0));
        tbl.push_back(mkv(c_wr(4'd3, 4'h5, 32'hAABBCCDD), c_idle(), 1'b0, 32'h0, 1'b0, 32'h0));
        tbl.push_back(mkv(c_rd(4'd3), c_rd(4'd3), 1'b1, 32'h11BB33DD, 1'b1, 32'h11BB33DD));
        tbl.push_back(mkv(c_wr(4'd2, 4'h1, 32'h000000FF), c_wr(4'd2, 4'hF, 32'hFFFF0000), 1'b0, 32'h0, 1'b0, 32'h0));
        tbl.push_back(mkv(c_rd(4'd2), c_rd(4'd9), 1'b1, 32'hFFFF00FF, 1'b1, 32'h0));
        tbl.push_back(mkv(c_wr(4'd5, 4'hF, 32'hCAFEF00D), c_rd(4'd5), 1'b0, 32'h0, 1'b1, 32'hCAFEF00D));
        tbl.push_back(mkv(mk_cmd(1'b1, 1'b1, 1'b1, 4'd6, 4'h3, 32'h0000BEEF), c_rd(4'd8), 1'b0, 32'h0, 1'b1, 32'h0));
        tbl.push_back(mkv(c_rd(4'd6), c_wr(4'd6, 4'hC, 32'h5A5A0000), 1'b1, 32'h5A5ABEEF, 1'b0, 32'h0));
        tbl.push_back(mkv(c_wr(4'd8, 4'hF, 32'hDEADBEEF), c_rd(4'd0), 1'b0, 32'h0, 1'b1, 32'h0));
        tbl.push_back(mkv(c_rd(4'd0), mk_cmd(1'b0, 1'b1, 1'b0, 4'd1, 4'h0, 32'h0), 1'b1, 32'h0, 1'b0, 32'h0));
        tbl.push_back(mkv(c_wr(4'd4, 4'hF, 32'h01020304), c_idle(), 1'b0, 32'h0, 1'b0, 32'h0));
        tbl.push_back(mkv(c_rd(4'd4), c_rd(4'd5), 1'b1, 32'h01020304, 1'b1, 32'hCAFEF00D));
        tbl.push_back(mkv(c_wr(4'd1, 4'h0, 32'hFFFFFFFF), c_wr(4'd1, 4'h2, 32'h0000AB00), 1'b0, 32'h0, 1'b0, 32'h0));
        tbl.push_back(mkv(mk_cmd(1'b0, 1'b0, 1'b1, 4'd1, 4'hF, 32'hFFFFFFFF), c_idle(), 1'b0, 32'h0, 1'b0, 32'h0));
        tbl.push_back(mkv(c_rd(4'd1), c_idle(), 1'b1, 32'h0000AB00, 1'b0, 32'h0));
        tbl.push_back(mkv(c_idle(), c_idle(), 1'b0, 32'h0, 1'b0, 32'h0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

        chk("hold a_data L1", r1_a_d, 32'h0000AB00);
        chk("hold a_data L2", r2_a_d, 32'h0000AB00);

        // Reads in flight when reset hits must not surface.
        drive(c_rd(4'd3), c_rd(4'd5));
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(c_idle(), c_idle());
        @(negedge clk);
        chk("inflight a_valid L1", 32'(r1_a_v), 32'd0);
        chk("inflight a_data L1", r1_a_d, 32'h0);
        chk("inflight a_valid L2", 32'(r2_a_v), 32'd0);
        chk("inflight b_valid L2", 32'(r2_b_v), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Abort the fill after words 0..3 have been cleared.
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("midfill wait", 32'(r1_a_w), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        measure_fill("fill2");

        p_av = 1'b0; p_ad = '0; p_bv = 1'b0; p_bd = '0;
        tbl.delete();
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(mkv(c_rd(4'(i)), c_rd(4'(7 - i)), 1'b1, 32'h0, 1'b1, 32'h0));
        end
        tbl.push_back(mkv(c_rd(4'd8), c_rd(4'd15), 1'b1, 32'h0, 1'b1, 32'h0));
        tbl.push_back(mkv(c_idle(), c_idle(), 1'b0, 32'h0, 1'b0, 32'h0));
        foreach (tbl[i]) apply(tbl[i], $sformatf("clr%0d", i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nios_dpram_pipelined.md
# nios_dpram_pipelined

Parametrised dual-port Avalon-MM on-chip RAM; next generation of the Nios II system's on-chip program/data memory. Both slave ports share one clock. It adds configurable read latency with `readdatavalid`, `waitrequest` back-pressure, an optional zero-fill engine after reset, deterministic write collision handling, and write-first read forwarding. It sits between the Nios II instruction/data masters (or a DMA) and the audio sample buffers.

## Interface
- `DATA_W`, 32: word width; multiple of 8.
- `DEPTH`, 50000: number of words.
- `ADDR_W`, 16: word-address width; 2^ADDR_W ≥ DEPTH.
- `READ_LATENCY`, 1: cycles from read acceptance to `readdatavalid`; legal values 1 or 2.
- `CLEAR_ON_RESET`, 1: 1 = zero-fill all words after reset; 0 = skip the fill.
- `clk` in 1: single clock for both ports.
- `reset` in 1: asynchronous, active-high.
- `a_chipselect`, `a_read`, `a_write` in 1 each: port A strobes.
- `a_address` in ADDR_W: port A word address.
- `a_byteenable` in DATA_W/8: port A byte lanes.
- `a_writedata` in DATA_W: port A write data.
- `a_readdata` out DATA_W: port A read data; registered.
- `a_readdatavalid` out 1: port A read data valid.
- `a_waitrequest` out 1: port A stall.
- `b_*`: identical set of ports for port B.

## Operation
- FSM states: RESET (reset asserted), CLEAR, RUN.
- Reset release with `CLEAR_ON_RESET`=1: go to CLEAR.
  - CLEAR writes 0 to one word per cycle, address 0..DEPTH-1 ascending.
  - After the final word (DEPTH-1), go to RUN.
- Reset release with `CLEAR_ON_RESET`=0: go directly to RUN on the first clock.
- `waitrequest` on both ports is high in RESET and CLEAR, and low in RUN. No other source of back-pressure exists.
- Reset asserted mid-CLEAR: the fill aborts, the counter returns to 0, and the fill restarts from 0 after release.
- Command acceptance: a command is accepted when `chipselect & (read|write) & ~waitrequest`.
- Write: only lanes with `byteenable`=1 are updated.
- Read: data is returned exactly READ_LATENCY cycles after acceptance. Back-to-back reads are accepted every cycle.
- Read and write asserted together on one port: the write is performed, the read is dropped, and no `readdatavalid` is generated.
- Both ports write the same address in the same cycle: merge per byte.
  - Where A's byteenable is set, A's byte is stored.
  - All other lanes take B's byte where B's byteenable is set; otherwise the old byte is kept.
- Read-during-write (same port or cross port, same address, same cycle): the read returns the post-write merged word (write-first).
- Address ≥ DEPTH:
  - Writes are ignored.
  - Reads return 0 with a normal `readdatavalid`.
- `readdata` holds its last value when `readdatavalid`=0.

## Timing
- Reset values: `readdata`=0 and `readdatavalid`=0 on both ports; `waitrequest`=1 on both ports; fill counter=0.
- READ_LATENCY=1: read accepted at edge n; `readdatavalid`=1 and `readdata` valid during cycle n+1.
- READ_LATENCY=2: one additional output register stage; valid during cycle n+2.
- Writes commit at the accepting edge. A read accepted at the next edge returns the new data.
- CLEAR duration: `waitrequest` is high for DEPTH cycles after reset release. It is low in cycle DEPTH+1 (DEPTH=8 → low at cycle 9).
- Reads in flight when reset asserts are discarded; no `readdatavalid` is produced for them.

## Structure
- Package `nios_dpram_pkg` holds:
  - state enum {RESET, CLEAR, RUN};
  - localparams for the legal READ_LATENCY range;
  - a byte-merge function (old word, new word, byteenable → merged word), shared by collision and forwarding logic.
- Sub-module `nios_dpram_rd_pipe` is instantiated once per port. It is a READ_LATENCY-deep valid/data shift pipeline with asynchronous clear.
- Top level contains the memory array, the fill FSM/counter, the write/merge logic, and the address range check.

## Test plan
- Fill: DEPTH=8, CLEAR_ON_RESET=1, reset released → `waitrequest` high 8 cycles; reads of words 0..7 all return 0 with `readdatavalid` at +1.
- Byte write: A writes 0x11223344 to addr 3 with be=0xF, then 0xAABBCCDD with be=0x5 → read returns 0x11BB33DD.
- Collision: same cycle, A writes 0x000000FF be=0x1 and B writes 0xFFFF0000 be=0xF to addr 2 → addr 2 reads 0xFFFF00FF.
- Forwarding: A writes 0xCAFEF00D to addr 5 while B reads addr 5 in the same cycle → B gets 0xCAFEF00D. With READ_LATENCY=2 the data arrives two cycles later.
- Range and reset: read addr DEPTH returns 0 with valid. Reset asserted at fill word 4 → after release the fill restarts at 0 and takes the full 8 cycles; pending read valids are suppressed.
